// File: rtl/quantum_job_scheduler.sv
// Round-robin scheduler sharing one quantum algorithm engine among NUM_REQ requesters.
// Optional build macro QSCHED_PRIORITY_EN: requester 0 always wins, others round-robin.
module quantum_job_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [2*NUM_REQ-1:0]   req_algo,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [1:0]             rsp_status,
  output logic [1:0]             algorithm_sel,
  output logic                   algo_start,
  output logic                   algo_abort,
  input  logic                   algorithm_done,
  input  logic                   algorithm_error,
  output logic                   busy,
  output logic [2:0]             grant_id,
  output logic [15:0]            jobs_completed,
  output logic [15:0]            jobs_timed_out
);
  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t            state, state_nx;
  logic [2:0]        id_q, last_grant, win;
  logic [1:0]        status_q, algo_w;
  logic [WD_W-1:0]   wdog;
  logic              found, expire;
  logic [NUM_REQ-1:0] cand;

  assign grant_id = id_q;
  assign expire   = (wdog == WD_W'(TIMEOUT_CYCLES - 1));
  assign algo_w   = 2'(req_algo >> {win, 1'b0});

  // Winner search: first candidate after last_grant, wrapping around.
  always_comb begin
    win   = 3'd0;
    found = 1'b0;
    cand  = req_valid;
`ifdef QSCHED_PRIORITY_EN
    if (req_valid[0]) begin
      win   = 3'd0;
      found = 1'b1;
    end
    cand[0] = 1'b0;
`endif
    for (int i = 1; i <= NUM_REQ; i++) begin
      int idx;
      idx = (int'(last_grant) + i) % NUM_REQ;
      if (!found && |(cand & (NUM_REQ'(1) << idx))) begin
        win   = 3'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    req_ready  = '0;
    rsp_valid  = '0;
    rsp_status = 2'b00;
    algo_start = 1'b0;
    algo_abort = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: if (found) begin
        req_ready = NUM_REQ'(1) << win;
        state_nx  = (algo_w == 2'b11) ? S_RESP : S_LAUNCH;
      end
      S_LAUNCH: begin
        algo_start = 1'b1;
        state_nx   = S_WAIT;
      end
      S_WAIT: begin
        // done takes precedence over a same-cycle watchdog expiry
        if (algorithm_done) begin
          state_nx = S_RESP;
        end else if (expire) begin
          algo_abort = 1'b1;
          state_nx   = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid  = NUM_REQ'(1) << id_q;
        rsp_status = status_q;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      id_q           <= 3'd0;
      status_q       <= 2'b00;
      last_grant     <= 3'(NUM_REQ - 1);
      wdog           <= '0;
      algorithm_sel  <= 2'b00;
      jobs_completed <= 16'd0;
      jobs_timed_out <= 16'd0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (found) begin
          id_q     <= win;
          status_q <= (algo_w == 2'b11) ? 2'b11 : 2'b00;
          // illegal jobs never reach the engine, so leave its selection alone
          if (algo_w != 2'b11) algorithm_sel <= algo_w;
`ifdef QSCHED_PRIORITY_EN
          if (win != 3'd0) last_grant <= win;
`else
          last_grant <= win;
`endif
        end
        S_LAUNCH: wdog <= '0;
        S_WAIT: begin
          if (algorithm_done)  status_q <= algorithm_error ? 2'b01 : 2'b00;
          else if (expire)     status_q <= 2'b10;
          else                 wdog     <= wdog + 1'b1;
        end
        S_RESP: begin
          if (jobs_completed != 16'hFFFF) jobs_completed <= jobs_completed + 16'd1;
          if (status_q == 2'b10 && jobs_timed_out != 16'hFFFF)
            jobs_timed_out <= jobs_timed_out + 16'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_quantum_job_scheduler.sv
// Directed bench for quantum_job_scheduler: cycle table plus hand sequences for RR, timeout, reset.
module tb_quantum_job_scheduler;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_valid, req_ready, rsp_valid;
  logic [7:0] req_algo;
  logic [1:0] rsp_status, algorithm_sel;
  logic       algo_start, algo_abort, algorithm_done, algorithm_error, busy;
  logic [2:0] grant_id;
  logic [15:0] jobs_completed, jobs_timed_out;
  int total = 0;
  int bad   = 0;

  quantum_job_scheduler #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_algo(req_algo),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_status(rsp_status),
    .algorithm_sel(algorithm_sel), .algo_start(algo_start), .algo_abort(algo_abort),
    .algorithm_done(algorithm_done), .algorithm_error(algorithm_error), .busy(busy),
    .grant_id(grant_id), .jobs_completed(jobs_completed), .jobs_timed_out(jobs_timed_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] v;
    logic [7:0] a;
    logic       d, e;
    logic [3:0] rdy;
    logic       st;
    logic [3:0] rsp;
    logic [1:0] stat;
    logic [1:0] sel;
    logic       bsy;
  } vec_t;
  vec_t tab[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_algo = '0;
    algorithm_done = 1'b0; algorithm_error = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Expects a grant to exp_id now; job finishes 3 cycles after start.
  task automatic run_job(input int exp_id, input logic [1:0] exp_sel);
    #1 chk($sformatf("job%0d ready", exp_id), 32'(req_ready), 32'(4'b0001 << exp_id));
    tick();
    #1 chk("job start", 32'(algo_start), 32'd1);
    chk("job sel launch", 32'(algorithm_sel), 32'(exp_sel));
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 3) algorithm_done = 1'b1;
      #1 chk("job sel wait", 32'(algorithm_sel), 32'(exp_sel));
    end
    tick();
    algorithm_done = 1'b0;
    #1 chk("job rsp", 32'(rsp_valid), 32'(4'b0001 << exp_id));
    chk("job status", 32'(rsp_status), 32'd0);
    chk("job sel resp", 32'(algorithm_sel), 32'(exp_sel));
    tick();
  endtask

  initial begin
    //            v        a      d     e     rdy      st    rsp      stat   sel    bsy
    tab[0]  = '{4'b0001, 8'h00, 1'b0, 1'b0, 4'b0001, 1'b0, 4'b0000, 2'b00, 2'd0, 1'b0};
    tab[1]  = '{4'b0000, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 2'b00, 2'd0, 1'b1};
    tab[2]  = '{4'b0000, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'b00, 2'd0, 1'b1};
    tab[3]  = '{4'b0000, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'b00, 2'd0, 1'b1};
    tab[4]  = '{4'b0000, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'b00, 2'd0, 1'b1};
    tab[5]  = '{4'b0000, 8'h00, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'b00, 2'd0, 1'b1};
    tab[6]  = '{4'b0000, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0001, 2'b00, 2'd0, 1'b1};
    tab[7]  = '{4'b0100, 8'h30, 1'b0, 1'b0, 4'b0100, 1'b0, 4'b0000, 2'b00, 2'd0, 1'b0};
    tab[8]  = '{4'b0000, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0100, 2'b11, 2'd0, 1'b1};
    tab[9]  = '{4'b1000, 8'h80, 1'b0, 1'b0, 4'b1000, 1'b0, 4'b0000, 2'b00, 2'd0, 1'b0};
    tab[10] = '{4'b0000, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 2'b00, 2'd2, 1'b1};
    tab[11] = '{4'b0000, 8'h00, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0000, 2'b00, 2'd2, 1'b1};
    tab[12] = '{4'b0000, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b1000, 2'b01, 2'd2, 1'b1};
    tab[13] = '{4'b0000, 8'h00, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'b00, 2'd2, 1'b0};
    tab[14] = '{4'b0000, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'b00, 2'd2, 1'b0};

    @(negedge clk);
    do_reset();
    #1 chk("rst ready", 32'(req_ready), 0);
    chk("rst rsp", 32'(rsp_valid), 0);
    chk("rst outs", 32'({rsp_status, algorithm_sel, algo_start, algo_abort, busy, grant_id}), 0);
    chk("rst counters", 32'({jobs_completed, jobs_timed_out}), 0);

    // single job, illegal algo, engine error, stray done in IDLE
    for (int i = 0; i < 15; i++) begin
      req_valid = tab[i].v; req_algo = tab[i].a;
      algorithm_done = tab[i].d; algorithm_error = tab[i].e;
      #1;
      chk($sformatf("row%0d ready", i),  32'(req_ready),     32'(tab[i].rdy));
      chk($sformatf("row%0d start", i),  32'(algo_start),    32'(tab[i].st));
      chk($sformatf("row%0d rsp", i),    32'(rsp_valid),     32'(tab[i].rsp));
      chk($sformatf("row%0d status", i), 32'(rsp_status),    32'(tab[i].stat));
      chk($sformatf("row%0d sel", i),    32'(algorithm_sel), 32'(tab[i].sel));
      chk($sformatf("row%0d busy", i),   32'(busy),          32'(tab[i].bsy));
      chk($sformatf("row%0d abort", i),  32'(algo_abort),    0);
      tick();
    end
    algorithm_done = 1'b0; algorithm_error = 1'b0;
    chk("tab completed", 32'(jobs_completed), 3);
    chk("tab timed_out", 32'(jobs_timed_out), 0);
    chk("tab grant_id", 32'(grant_id), 3);

    // round-robin with all requesters pending; algos r0=01 r1=10 r2=00 r3=01
    do_reset();
    req_valid = 4'b1111; req_algo = 8'b01_00_10_01;
    for (int j = 0; j < 5; j++) run_job(j % 4, 2'(req_algo >> (2 * (j % 4))));
    chk("rr completed", 32'(jobs_completed), 5);

    // watchdog expiry, then done landing exactly on the expiry cycle
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) do_reset();
      req_valid = 4'b0001; req_algo = 8'h00;
      #1 chk("to ready", 32'(req_ready), 32'(4'b0001));
      tick();
      req_valid = 4'b0000;
      for (int c = 0; c < 15; c++) begin
        tick();
        #1 chk("to no early abort", 32'(algo_abort), 0);
      end
      tick();
      if (pass == 1) algorithm_done = 1'b1;
      #1 chk("to abort", 32'(algo_abort), (pass == 0) ? 1 : 0);
      tick();
      algorithm_done = 1'b0;
      #1 chk("to rsp", 32'(rsp_valid), 32'(4'b0001));
      chk("to status", 32'(rsp_status), (pass == 0) ? 2 : 0);
      tick();
      chk("to timed_out", 32'(jobs_timed_out), 1);
      chk("to completed", 32'(jobs_completed), pass + 1);
    end

    // reset in the middle of WAIT
    do_reset();
    req_valid = 4'b0010; req_algo = 8'b0000_1000;
    #1 chk("mid ready", 32'(req_ready), 32'(4'b0010));
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    #1 chk("mid sel", 32'(algorithm_sel), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 chk("mid outs", 32'({rsp_valid, rsp_status, algorithm_sel, algo_start, algo_abort, busy, grant_id}), 0);
    chk("mid counters", 32'({jobs_completed, jobs_timed_out}), 0);
    req_valid = 4'b1111;
    #1 chk("mid rr restart", 32'(req_ready), 32'(4'b0001));
    tick();
    req_valid = 4'b0000;
    for (int c = 0; c < 4; c++) tick();

`ifdef QSCHED_PRIORITY_EN
    do_reset();
    req_valid = 4'b1111; req_algo = 8'h00;
    for (int j = 0; j < 3; j++) run_job(0, 2'd0);
    req_valid = 4'b1110;
    for (int j = 1; j < 4; j++) run_job(j, 2'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench time limit");
  end
endmodule
